rf_trace_buf: RTL and testbench

RF_TRACE_BUF -- requirements
Module: rf_trace_buf

---
 rtl/rf_trace_pkg.sv | 14 +
 rtl/rf_trace_fifo.sv | 69 ++++++
 rtl/rf_trace_buf.sv | 85 ++++++++
 tb/tb_rf_trace_buf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_trace_pkg.sv
// Shared definitions for the register-file write trace buffer.
package rf_trace_pkg;

  localparam int TRC_DROP_NEW  = 0;
  localparam int TRC_OVERWRITE = 1;

  localparam int OVF_W = 16;

  // Stored entry is {wa, wd, ts}
  function automatic int entry_w(input int addr_w, input int data_w, input int ts_w);
    return addr_w + data_w + ts_w;
  endfunction

endpackage

// File: rtl/rf_trace_fifo.sv
// First-word-fall-through entry storage with a selectable full-buffer policy.
module rf_trace_fifo
  import rf_trace_pkg::*;
#(
  parameter int W     = 53,
  parameter int DEPTH = 16,
  parameter int MODE  = TRC_DROP_NEW
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_evt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             do_write;

  // A pop in the same cycle frees the slot, so only a push without pop overflows
  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    do_pop   = pop && !empty;
    ovf_evt  = push && full && !do_pop;
    do_write = push && (!ovf_evt || (MODE == TRC_OVERWRITE));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || (ovf_evt && (MODE == TRC_OVERWRITE)))
        rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !do_pop && !ovf_evt)
        count <= count + 1'b1;
      else if (do_pop && !do_write)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !clr)
      mem[wr_ptr] <= wdata;
  end

  // Gating on empty keeps the outputs at zero during and after reset
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rf_trace_buf.sv
// Register-file write tracer: qualifies captures, timestamps them and queues them.
module rf_trace_buf
  import rf_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int MODE   = TRC_DROP_NEW
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   rf_in_wre,
  input  logic [ADDR_W-1:0]      rf_in_wa,
  input  logic [DATA_W-1:0]      rf_in_wd,
  input  logic                   trc_en,
  input  logic [2**ADDR_W-1:0]   trc_mask,
  input  logic                   trc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_wa,
  output logic [DATA_W-1:0]      out_wd,
  output logic [TS_W-1:0]        out_ts,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [OVF_W-1:0]       ovf_cnt
);

  localparam int EW = entry_w(ADDR_W, DATA_W, TS_W);

  logic [TS_W-1:0] ts;
  logic            capture;
  logic            push;
  logic            pop;
  logic            ovf_evt;
  logic [EW-1:0]   rdata;

  // Register 0 is hardwired and never traced; a flush swallows the cycle's traffic
  always_comb begin
    capture = trc_en && rf_in_wre && (rf_in_wa != '0) && trc_mask[rf_in_wa];
    push    = capture && !trc_clr;
    pop     = out_valid && out_ready && !trc_clr;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      ts <= '0;
    else if (trc_clr)
      ts <= '0;
    else
      ts <= ts + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      ovf_cnt <= '0;
    else if (trc_clr)
      ovf_cnt <= '0;
    else if (ovf_evt && (ovf_cnt != '1))
      ovf_cnt <= ovf_cnt + 1'b1;
  end

  rf_trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .MODE  (MODE)
  ) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .clr     (trc_clr),
    .push    (push),
    .pop     (pop),
    .wdata   ({rf_in_wa, rf_in_wd, ts}),
    .rdata   (rdata),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .ovf_evt (ovf_evt)
  );

  assign out_valid = !empty;
  assign {out_wa, out_wd, out_ts} = rdata;

endmodule

// File: tb/tb_rf_trace_buf.sv
// Scoreboard bench for rf_trace_buf, exercising drop-new and overwrite-oldest instances side by side.
module tb_rf_trace_buf;
  import rf_trace_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int EW     = ADDR_W + DATA_W + TS_W;

  typedef logic [EW-1:0] entry_t;

  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              rf_in_wre = 1'b0;
  logic [ADDR_W-1:0] rf_in_wa = '0;
  logic [DATA_W-1:0] rf_in_wd = '0;
  logic              trc_en = 1'b0;
  logic [31:0]       trc_mask = '1;
  logic              trc_clr = 1'b0;
  logic              out_ready = 1'b0;

  logic              d_valid, d_full, d_empty;
  logic [ADDR_W-1:0] d_wa;
  logic [DATA_W-1:0] d_wd;
  logic [TS_W-1:0]   d_ts;
  logic [4:0]        d_count;
  logic [15:0]       d_ovf;

  logic              o_valid, o_full, o_empty;
  logic [ADDR_W-1:0] o_wa;
  logic [DATA_W-1:0] o_wd;
  logic [TS_W-1:0]   o_ts;
  logic [4:0]        o_count;
  logic [15:0]       o_ovf;

  int n_checks = 0;
  int n_fail = 0;

  entry_t exp_drop[$];
  entry_t exp_ovw[$];
  entry_t e_drop, e_ovw;
  logic [TS_W-1:0] ts_model = '0;

  rf_trace_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W), .MODE(TRC_DROP_NEW)) dut_drop (
    .clk(clk), .rst_l(rst_l), .rf_in_wre(rf_in_wre), .rf_in_wa(rf_in_wa), .rf_in_wd(rf_in_wd),
    .trc_en(trc_en), .trc_mask(trc_mask), .trc_clr(trc_clr), .out_valid(d_valid), .out_ready(out_ready),
    .out_wa(d_wa), .out_wd(d_wd), .out_ts(d_ts), .count(d_count), .full(d_full), .empty(d_empty),
    .ovf_cnt(d_ovf)
  );

  rf_trace_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W), .MODE(TRC_OVERWRITE)) dut_ovw (
    .clk(clk), .rst_l(rst_l), .rf_in_wre(rf_in_wre), .rf_in_wa(rf_in_wa), .rf_in_wd(rf_in_wd),
    .trc_en(trc_en), .trc_mask(trc_mask), .trc_clr(trc_clr), .out_valid(o_valid), .out_ready(out_ready),
    .out_wa(o_wa), .out_wd(o_wd), .out_ts(o_ts), .count(o_count), .full(o_full), .empty(o_empty),
    .ovf_cnt(o_ovf)
  );

  always #5 clk = ~clk;

  // Reference timestamp: free-running, zeroed by reset or flush
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l)
      ts_model <= '0;
    else if (trc_clr)
      ts_model <= '0;
    else
      ts_model <= ts_model + 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus and records the entries each policy should hold
  task automatic applyStimulus(input logic en, input logic wre, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic [31:0] mask,
                               input logic ready, input logic clr);
    logic   cap;
    entry_t e;
    trc_en    = en;
    rf_in_wre = wre;
    rf_in_wa  = wa;
    rf_in_wd  = wd;
    trc_mask  = mask;
    out_ready = ready;
    trc_clr   = clr;
    cap = en && wre && (wa != '0) && mask[wa];
    e   = {wa, wd, ts_model};
    if (clr) begin
      exp_drop.delete();
      exp_ovw.delete();
    end else if (cap) begin
      if (exp_drop.size() < DEPTH || ready)
        exp_drop.push_back(e);
      if (exp_ovw.size() >= DEPTH && !ready)
        void'(exp_ovw.pop_front());
      exp_ovw.push_back(e);
    end
    step();
    rf_in_wre = 1'b0;
    trc_clr   = 1'b0;
  endtask

  // Monitor: every accepted head entry is compared against the scoreboard front
  always @(negedge clk) begin
    if (rst_l && !trc_clr) begin
      if (d_valid && out_ready) begin
        if (exp_drop.size() == 0) begin
          checkOutput("drop_unexpected_pop", {d_wa, d_wd, d_ts}, 64'd0);
        end else begin
          e_drop = exp_drop.pop_front();
          checkOutput("drop_head_entry", {d_wa, d_wd, d_ts}, e_drop);
        end
      end
      if (o_valid && out_ready) begin
        if (exp_ovw.size() == 0) begin
          checkOutput("ovw_unexpected_pop", {o_wa, o_wd, o_ts}, 64'd0);
        end else begin
          e_ovw = exp_ovw.pop_front();
          checkOutput("ovw_head_entry", {o_wa, o_wd, o_ts}, e_ovw);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) step();
    checkOutput("rst_count", d_count, 0);
    checkOutput("rst_empty", d_empty, 1);
    checkOutput("rst_full", d_full, 0);
    checkOutput("rst_valid", d_valid, 0);
    checkOutput("rst_ovf", d_ovf, 0);
    checkOutput("rst_out_fields", {d_wa, d_wd, d_ts}, 0);
    checkOutput("rst_ovw_valid", o_valid, 0);

    // First capture lands at ts=5 after five idle cycles
    rst_l = 1'b1;
    repeat (5) step();
    checkOutput("pre_capture_valid", d_valid, 0);
    applyStimulus(1, 1, 5'd3, 32'h1234, '1, 0, 0);
    checkOutput("first_valid", d_valid, 1);
    checkOutput("first_wa", d_wa, 3);
    checkOutput("first_wd", d_wd, 32'h1234);
    checkOutput("first_ts", d_ts, 5);
    applyStimulus(0, 0, 5'd0, 32'h0, '1, 1, 0);
    checkOutput("drain_first_count", d_count, 0);

    // Filtered writes: register 0, masked register 7, trace disabled
    applyStimulus(1, 1, 5'd0, 32'hDEAD, '1, 0, 0);
    applyStimulus(1, 1, 5'd7, 32'hBEEF, ~32'h80, 0, 0);
    applyStimulus(0, 1, 5'd9, 32'hCAFE, '1, 0, 0);
    checkOutput("filter_count", d_count, 0);
    checkOutput("filter_valid", d_valid, 0);
    checkOutput("filter_ovw_count", o_count, 0);

    // 18 captures into a 16-deep buffer with no consumer
    for (int i = 0; i < 18; i++)
      applyStimulus(1, 1, 5'(i + 1), 32'hA000_0000 + i, '1, 0, 0);
    checkOutput("drop_full_count", d_count, 16);
    checkOutput("drop_full_flag", d_full, 1);
    checkOutput("drop_ovf", d_ovf, 2);
    checkOutput("drop_head_wa", d_wa, 1);
    checkOutput("drop_head_wd", d_wd, 32'hA000_0000);
    checkOutput("ovw_full_count", o_count, 16);
    checkOutput("ovw_full_flag", o_full, 1);
    checkOutput("ovw_ovf", o_ovf, 2);
    checkOutput("ovw_head_wa", o_wa, 3);
    checkOutput("ovw_head_wd", o_wd, 32'hA000_0002);

    // Capture and pop together while full: no overflow, head moves by one
    applyStimulus(1, 1, 5'd19, 32'hA000_0012, '1, 1, 0);
    out_ready = 1'b0;
    checkOutput("fullpop_drop_ovf", d_ovf, 2);
    checkOutput("fullpop_drop_count", d_count, 16);
    checkOutput("fullpop_drop_head", d_wa, 2);
    checkOutput("fullpop_ovw_ovf", o_ovf, 2);
    checkOutput("fullpop_ovw_count", o_count, 16);
    checkOutput("fullpop_ovw_head", o_wa, 4);

    repeat (16) applyStimulus(0, 0, 5'd0, 32'h0, '1, 1, 0);
    out_ready = 1'b0;
    checkOutput("drained_drop_count", d_count, 0);
    checkOutput("drained_ovw_count", o_count, 0);
    checkOutput("drained_drop_empty", d_empty, 1);

    // Flush with a simultaneous capture and pop request
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 5'(20 + i), 32'hB000_0000 + i, '1, 0, 0);
    applyStimulus(1, 1, 5'd5, 32'h55, '1, 1, 1);
    out_ready = 1'b0;
    checkOutput("clr_drop_count", d_count, 0);
    checkOutput("clr_drop_ovf", d_ovf, 0);
    checkOutput("clr_drop_valid", d_valid, 0);
    checkOutput("clr_ovw_count", o_count, 0);
    checkOutput("clr_ovw_ovf", o_ovf, 0);
    applyStimulus(1, 1, 5'd6, 32'h66, '1, 0, 0);
    checkOutput("post_clr_ts", d_ts, 0);
    checkOutput("post_clr_wa", d_wa, 6);

    // Asynchronous reset in the middle of a drain
    applyStimulus(1, 1, 5'd8, 32'h88, '1, 0, 0);
    applyStimulus(1, 1, 5'd10, 32'hAA, '1, 0, 0);
    applyStimulus(0, 0, 5'd0, 32'h0, '1, 1, 0);
    #2;
    rst_l = 1'b0;
    #1;
    exp_drop.delete();
    exp_ovw.delete();
    checkOutput("async_rst_count", d_count, 0);
    checkOutput("async_rst_valid", d_valid, 0);
    checkOutput("async_rst_ovf", d_ovf, 0);
    checkOutput("async_rst_fields", {d_wa, d_wd, d_ts}, 0);
    checkOutput("async_rst_ovw_count", o_count, 0);
    out_ready = 1'b0;
    step();
    step();

    // Capture on the very first edge after reset release
    rst_l = 1'b1;
    applyStimulus(1, 1, 5'd9, 32'h99, '1, 0, 0);
    checkOutput("first_edge_valid", d_valid, 1);
    checkOutput("first_edge_ts", d_ts, 0);
    checkOutput("first_edge_wa", d_wa, 9);
    applyStimulus(0, 0, 5'd0, 32'h0, '1, 1, 0);
    out_ready = 1'b0;
    step();
    checkOutput("final_drop_count", d_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
